// File: rtl/multi_motor_controller.sv
// Multi-channel H-bridge PWM controller: shared period counter, per-channel
// double-buffered settings, dead-time insertion. Define MULTI_MOTOR_RAMP_EN for duty ramping.
module multi_motor_controller #(
  parameter int CHANNELS  = 8,
  parameter int PWM_WIDTH = 16,
  parameter int DEAD_TIME = 200,
  parameter int RAMP_STEP = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PWM_WIDTH-1:0]    period,
  input  logic                    wr_en,
  input  logic [4:0]              wr_chan,
  input  logic [PWM_WIDTH-1:0]    wr_duty,
  input  logic                    wr_dir,
  input  logic                    wr_on,
  input  logic                    wr_mode,
  output logic [4*CHANNELS-1:0]   out,
  output logic                    period_sync
);

  // Drive-stage state: bit 1 = bridge driven, bit 0 = polarity when driven.
  localparam logic [1:0] DRV_OFF = 2'b00;
  localparam logic [1:0] DRV_0   = 2'b10;
  localparam logic [1:0] DRV_1   = 2'b11;

  logic [PWM_WIDTH-1:0] cnt_p0;
  logic [PWM_WIDTH-1:0] period_active;
  logic                 boundary;

  logic [PWM_WIDTH-1:0] p_duty [CHANNELS];
  logic [CHANNELS-1:0]  p_dir, p_on, p_mode;
  logic [PWM_WIDTH-1:0] a_duty [CHANNELS];
  logic [CHANNELS-1:0]  a_dir, a_on, a_mode;

  function automatic logic [3:0] pattern(input logic [1:0] drv);
    case (drv)
      DRV_1:   pattern = 4'b1001;
      DRV_0:   pattern = 4'b0110;
      default: pattern = 4'b0000;
    endcase
  endfunction

  function automatic logic [1:0] drive(input logic [PWM_WIDTH-1:0] cnt,
                                       input logic [PWM_WIDTH-1:0] duty,
                                       input logic dir, input logic on,
                                       input logic mode);
    if (!on)
      drive = DRV_OFF;
    else if (cnt < duty)
      drive = {1'b1, dir};
    else if (mode)
      drive = DRV_OFF;
    else
      drive = {1'b1, ~dir};
  endfunction

`ifdef MULTI_MOTOR_RAMP_EN
  function automatic logic [PWM_WIDTH-1:0] ramp(input logic [PWM_WIDTH-1:0] cur,
                                                input logic [PWM_WIDTH-1:0] tgt);
    logic [PWM_WIDTH-1:0] step;
    step = PWM_WIDTH'(RAMP_STEP);
    if (tgt > cur)
      ramp = (tgt - cur > step) ? cur + step : tgt;
    else
      ramp = (cur - tgt > step) ? cur - step : tgt;
  endfunction
`endif

  assign boundary = (cnt_p0 == period_active);

  // Stage p0: period counter, pending bank and commit into the active bank
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p0        <= '0;
      period_active <= '0;
      period_sync   <= 1'b0;
      p_dir  <= '0;
      p_on   <= '0;
      p_mode <= '0;
      a_dir  <= '0;
      a_on   <= '0;
      a_mode <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        p_duty[k] <= '0;
        a_duty[k] <= '0;
      end
    end else begin
      period_sync <= boundary;
      if (boundary) begin
        cnt_p0        <= '0;
        period_active <= period;
        a_dir  <= p_dir;
        a_on   <= p_on;
        a_mode <= p_mode;
        for (int k = 0; k < CHANNELS; k++) begin
`ifdef MULTI_MOTOR_RAMP_EN
          a_duty[k] <= ramp(a_duty[k], p_duty[k]);
`else
          a_duty[k] <= p_duty[k];
`endif
        end
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end
      // Non-blocking update: a boundary-cycle write lands after the commit above.
      for (int k = 0; k < CHANNELS; k++) begin
        if (wr_en && wr_chan == 5'(k)) begin
          p_duty[k] <= wr_duty;
          p_dir[k]  <= wr_dir;
          p_on[k]   <= wr_on;
          p_mode[k] <= wr_mode;
        end
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    logic [1:0] drv_p1;
    logic [3:0] out_p2;

    // Stage p1: per-channel drive decision
    always_ff @(posedge clk) begin
      if (reset)
        drv_p1 <= DRV_OFF;
      else
        drv_p1 <= drive(cnt_p0, a_duty[k], a_dir[k], a_on[k], a_mode[k]);
    end

    // Stage p2: dead-time blanking and gate pattern
    if (DEAD_TIME == 0) begin : g_nodead
      always_ff @(posedge clk) begin
        if (reset)
          out_p2 <= 4'b0000;
        else
          out_p2 <= pattern(drv_p1);
      end
    end else begin : g_dead
      localparam int DW = $clog2(DEAD_TIME + 1);
      logic [DW-1:0] dead_cnt, dead_next;
      logic [1:0]    drv_p2;

      always_comb begin
        dead_next = dead_cnt;
        if (drv_p1 != drv_p2)
          dead_next = '0;
        else if (dead_cnt < DW'(DEAD_TIME))
          dead_next = dead_cnt + DW'(1);
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          dead_cnt <= DW'(DEAD_TIME);
          drv_p2   <= DRV_OFF;
          out_p2   <= 4'b0000;
        end else begin
          dead_cnt <= dead_next;
          drv_p2   <= drv_p1;
          out_p2   <= (dead_next == DW'(DEAD_TIME)) ? pattern(drv_p1) : 4'b0000;
        end
      end
    end

    assign out[4*k +: 4] = out_p2;
  end

endmodule

// File: doc/multi_motor_controller.md
# multi_motor_controller

Multi-channel H-bridge PWM controller and the parametrised successor to the single-channel motor controller. It drives CHANNELS H-bridges from one shared PWM period counter. Each channel has a per-channel duty cycle, direction, enable and drive mode, and these settings load through a write port and commit glitch-free at the period boundary. Each channel has dead-time insertion, and duty ramping is optional. It sits between the host register interface and the H-bridge gate-drive pins.

## Interface
- CHANNELS, 8: number of H-bridge channels (1..32).
- PWM_WIDTH, 16: width of period, duty and the counter.
- DEAD_TIME, 200: cycles all four gates are held low after any drive-state change; 0 disables.
- RAMP_STEP, 1: maximum duty change per period when ramping is compiled in.

- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- period  in  PWM_WIDTH  PWM period minus 1; sampled only at the period boundary.
- wr_en  in  1  single-cycle write strobe.
- wr_chan  in  5  target channel; writes with wr_chan >= CHANNELS are ignored.
- wr_duty  in  PWM_WIDTH  duty cycle to load.
- wr_dir  in  1  direction: 1 selects drive pattern 1001, 0 selects 0110.
- wr_on  in  1  channel enable.
- wr_mode  in  1  0 = locked-antiphase, 1 = sign-magnitude.
- out  out  4*CHANNELS  gate drives; channel k is out[4k+3:4k].
- period_sync  out  1  one-cycle pulse in the cycle after a commit.

## Operation
- Counter: counts 0..period_active and wraps to 0, giving a PWM period of period_active+1 cycles. The boundary is the cycle where counter == period_active.
- Pending bank: per channel {duty, dir, on, mode}. A write with wr_en=1 updates the addressed channel's pending entry at that edge.
- Commit: at the boundary edge, active ← pending for all channels and period_active ← period.
  - Commit reads pending as it stood before the edge.
  - A write in the boundary cycle therefore commits at the next boundary.
- Per-channel drive stage (registered):
  - on=0: off.
  - mode 0 (locked-antiphase): counter < duty gives drive dir; otherwise drive ~dir.
  - mode 1 (sign-magnitude): counter < duty gives drive dir; otherwise off (coast).
  - Comparison is unsigned. duty > period_active gives 100 % dir. duty = 0 gives a constant ~dir (mode 0) or off (mode 1).
- Pattern encoding: drive 1 → 1001, drive 0 → 0110, off → 0000.
- Dead-time stage, per channel:
  - Any change in the drive-stage state (including off↔on) zeroes that channel's dead counter.
  - out shows 0000 while the counter < DEAD_TIME; the counter saturates at DEAD_TIME.
  - A further change during dead time restarts the count.
- Channels are fully independent. No two complementary gate pairs (bits 3/2 and 1/0 high together) may ever be asserted.

## Timing
- Reset:
  - counter = 0 and period_active = 0.
  - All pending and active entries are 0 (duty 0, off).
  - Dead counters are set to DEAD_TIME.
  - out = 0 and period_sync = 0.
- Latency: counter value at cycle n → drive stage at n+1 → out at n+2 (when the dead counter is saturated).
- Dead time: a drive change seen at the drive stage in cycle m gives out = 0000 for cycles m+1..m+DEAD_TIME. The new pattern appears at m+DEAD_TIME+1.
- period_sync is high for exactly one cycle, the cycle after each commit edge.
- Reset asserted mid-period or mid-dead-time returns everything to the reset state on the next edge. out is 0 on the following cycle.
- Changing period takes effect only at the next commit.
- When period_active < current counter cannot occur: the counter wraps on period_active only.

## Configuration
- MULTI_MOTOR_RAMP_EN:
  - Defined: at each commit, active duty moves toward pending duty by at most RAMP_STEP, saturating at the target. dir, on, mode and period commit immediately. A direction reversal ramps from the current duty.
  - Undefined: active duty ← pending duty in one commit, and RAMP_STEP is unused.

## Test plan
- Reset, then period=9, write ch0 duty=3 dir=1 on=1 mode=0, DEAD_TIME=0 → after the next boundary, out[3:0] repeats 1001×3 then 0110×7 cycles.
- ch1 mode=1 duty=5 period=9 → out[7:4] repeats 1001×5 then 0000×5. Other channels stay 0000.
- DEAD_TIME=4, ch0 antiphase duty=3 → every 1001↔0110 transition is preceded by exactly 4 cycles of 0000.
- Write ch2 duty=7 in the boundary cycle → ch2 keeps its old duty for one full period, then uses 7. Write with wr_chan=CHANNELS → no change to any channel.
- MULTI_MOTOR_RAMP_EN, RAMP_STEP=2, duty 0→7 → active duty is 2, 4, 6, 7 over successive periods. With the macro undefined, active duty is 7 after one commit.
- Assert reset mid-dead-time with 0110 pending → out=0 the next cycle and period_sync=0. The channel stays off until it is rewritten.
